sw_max_tracker: RTL and testbench
=================================

# sw_max_tracker

Downstream collector for the Smith-Waterman systolic PE chain. It consumes the V score stream leaving the last PE, one cell per reference base. It tracks the best score and the reference position where that score occurs, and counts cells at or above a hit threshold. At the end of each reference pass it presents one result record to the host interface through a valid/ready handshake.

## Interface
Parameters:
- SCORE_WIDTH, 10: width of the V score; two's complement.
- POS_WIDTH, 16: width of the reference position, the length and the hit counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous and active-high.
- stall  in  1  global array stall; same net as the PE stall.
- start  in  1  one-cycle pulse that begins a new reference pass.
- ref_len  in  POS_WIDTH  number of cells in the pass; sampled on start.
- threshold  in  SCORE_WIDTH  signed hit threshold; sampled on start.
- V_in  in  SCORE_WIDTH  V_out of the last PE.
- init_in  in  1  init_out of the last PE; marks V_in as a valid cell.
- best_score  out  SCORE_WIDTH  maximum V seen in the pass, signed.
- best_pos  out  POS_WIDTH  cell index (0-based) of the first occurrence of best_score.
- hit_count  out  POS_WIDTH  number of cells with V_in >= threshold; saturating.
- result_valid  out  1  result record is available.
- result_ready  in  1  consumer accepts the record.
- busy  out  1  high while in SCAN.

## Operation
- FSM states: IDLE, SCAN, REPORT.
- IDLE -> SCAN on start when ref_len != 0.
  - Clears best_score to 0, best_pos to 0, hit_count to 0 and pos_cnt to 0.
  - Latches ref_len and threshold.
- IDLE -> REPORT on start when ref_len == 0; the record is all zeros.
- In SCAN, a valid cell is init_in=1 with stall=0. For each valid cell:
  - if V_in > best_score (signed, strict): best_score <= V_in and best_pos <= pos_cnt. Ties keep the earlier position.
  - if V_in >= threshold (signed): hit_count increments, saturating at all-ones.
  - pos_cnt increments.
  - when pos_cnt == ref_len-1: go to REPORT.
- best_score starts at 0. SW scores are non-negative, so an all-zero pass reports best_score=0 and best_pos=0.
- REPORT holds result_valid=1 and all three result outputs stable until result_valid & result_ready & !stall. The FSM then returns to IDLE.
- Cells with init_in=0 are ignored in every state.
- Cells arriving in IDLE or REPORT are dropped.
- Cells on the cycle start is sampled are dropped. Counting begins the cycle after start.
- start in SCAN or REPORT aborts the current pass:
  - result_valid drops, the registers are re-cleared and the new ref_len and threshold are latched.
  - The FSM goes to SCAN, or to REPORT if the new ref_len=0.
- start while stall=1 is ignored.
- stall=1 freezes all registers, the FSM and the handshake. Outputs hold their values.
- Reset values: FSM=IDLE, best_score=0, best_pos=0, hit_count=0, result_valid=0, busy=0.
- Reset mid-pass discards the pass; no partial record is emitted.

## Timing
- Each result register updates on the edge after the cell is accepted.
- The last cell's contribution and result_valid=1 are both visible the cycle after the last valid cell.
- For a ref_len=0 start, result_valid=1 appears the cycle after start.
- Handshake completes on an edge with result_valid & result_ready & !stall. result_valid=0 and IDLE follow on the next cycle.
- result_ready may be held high permanently; the minimum REPORT dwell is then one cycle.
- Throughput: one cell per cycle with no bubbles.
- Back-to-back passes need one IDLE cycle, then start.

## Structure
- Shared package sw_pkg holds:
  - the state enum {IDLE, SCAN, REPORT};
  - the SCORE_WIDTH default (10), matching the PE;
  - the POS_WIDTH default.
- Single module; no sub-module. The comparator and the saturating counter stay inline.
- Signed compares use explicitly signed-cast operands.

## Test plan
- **PE test-1 stream.** threshold=10, ref_len=8, V stream 10,8,10,8,10,8,7,10 with init_in=1 each cycle.
  - Expect best_score=10, best_pos=0 and hit_count=4.
  - result_valid must rise one cycle after the 8th cell.
- **PE test-3 stream.** threshold=10, ref_len=8, V stream 8,8,8,8,8,8,20,18.
  - Expect best_score=20, best_pos=6 and hit_count=2.
  - Holding result_ready=0 for 5 cycles keeps the record stable; releasing it gives result_valid=0 and IDLE on the next cycle.
- **Gaps and stall.** Same test-1 stream with init_in=0 bubbles and stall=1 inserted on cells 3 and 6; V_in is garbage (e.g. 500) during the bubbles and stalls.
  - The result is identical to the first scenario.
  - A V_in=20 with init_in=1 and stall=1 must not count.
- **Abort and restart.** start after 4 cells of a pass, then a new pass with ref_len=2 and V stream 3,5.
  - Expect best_score=5, best_pos=1, hit_count=0 with threshold=10.
  - No record is emitted for the aborted pass.
- **Zero length and reset.** start with ref_len=0.
  - result_valid=1 the next cycle, with a zero record.
  - rst asserted mid-SCAN returns all outputs to their reset values on the next edge.
- **Saturation.** Use POS_WIDTH=4 and threshold=0 with 15 cells of value 1.
  - Expect hit_count=15.
  - A 16-cell pass is not allowed (ref_len is 4 bits, max 15), so feed 15 cells and confirm there is no wrap.

Source files
------------

// File: rtl/sw_pkg.sv
// Shared definitions for the Smith-Waterman datapath: tracker FSM states and
// default widths that must agree with the PE chain.
package sw_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam int SCORE_WIDTH_DEF = 10;
    localparam int POS_WIDTH_DEF   = 16;

endpackage

// File: rtl/sw_max_tracker.sv
// Collects the V score stream leaving the last PE: best score, first position
// of that score and a saturating hit count, reported once per reference pass.
module sw_max_tracker
    import sw_pkg::*;
#(
    parameter int SCORE_WIDTH = SCORE_WIDTH_DEF,
    parameter int POS_WIDTH   = POS_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   start,
    input  logic [POS_WIDTH-1:0]   ref_len,
    input  logic [SCORE_WIDTH-1:0] threshold,
    input  logic [SCORE_WIDTH-1:0] V_in,
    input  logic                   init_in,
    output logic [SCORE_WIDTH-1:0] best_score,
    output logic [POS_WIDTH-1:0]   best_pos,
    output logic [POS_WIDTH-1:0]   hit_count,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic                   busy
);

    state_t                 state_reg;
    state_t                 state_next;
    logic [SCORE_WIDTH-1:0] r_best_score;
    logic [POS_WIDTH-1:0]   r_best_pos;
    logic [POS_WIDTH-1:0]   r_hit_count;
    logic [POS_WIDTH-1:0]   r_pos_cnt;
    logic [POS_WIDTH-1:0]   r_ref_len;
    logic [SCORE_WIDTH-1:0] r_threshold;

    logic w_cell_valid;
    logic w_last_cell;
    logic w_new_best;
    logic w_hit;
    logic w_hit_full;

    // A start on the same cycle wins over any cell, so that cell is dropped.
    assign w_cell_valid = init_in && !stall && !start && (state_reg == SCAN);
    assign w_last_cell  = (r_pos_cnt == r_ref_len - POS_WIDTH'(1));
    assign w_new_best   = $signed(V_in) > $signed(r_best_score);
    assign w_hit        = $signed(V_in) >= $signed(r_threshold);
    assign w_hit_full   = &r_hit_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (!stall) begin
            if (start) begin
                state_next = (ref_len == '0) ? REPORT : SCAN;
            end else begin
                case (state_reg)
                    SCAN: begin
                        if (w_cell_valid && w_last_cell) begin
                            state_next = REPORT;
                        end
                    end
                    REPORT: begin
                        if (result_ready) begin
                            state_next = IDLE;
                        end
                    end
                    default: state_next = state_reg;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_best_score <= '0;
            r_best_pos   <= '0;
            r_hit_count  <= '0;
            r_pos_cnt    <= '0;
            r_ref_len    <= '0;
            r_threshold  <= '0;
        end else if (!stall) begin
            if (start) begin
                r_best_score <= '0;
                r_best_pos   <= '0;
                r_hit_count  <= '0;
                r_pos_cnt    <= '0;
                r_ref_len    <= ref_len;
                r_threshold  <= threshold;
            end else if (w_cell_valid) begin
                // Strict compare keeps the earliest position on ties.
                if (w_new_best) begin
                    r_best_score <= V_in;
                    r_best_pos   <= r_pos_cnt;
                end
                if (w_hit && !w_hit_full) begin
                    r_hit_count <= r_hit_count + POS_WIDTH'(1);
                end
                r_pos_cnt <= r_pos_cnt + POS_WIDTH'(1);
            end
        end
    end

    assign best_score   = r_best_score;
    assign best_pos     = r_best_pos;
    assign hit_count    = r_hit_count;
    assign result_valid = (state_reg == REPORT);
    assign busy         = (state_reg == SCAN);

endmodule

// File: tb/tb_sw_max_tracker.sv
// Self-checking bench for sw_max_tracker: vector table, directed corner cases
// and randomized passes against a queue-based reference model.
module tb_sw_max_tracker;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        start;
    logic [15:0] ref_len;
    logic [9:0]  threshold;
    logic [9:0]  V_in;
    logic        init_in;
    logic        result_ready;

    logic [9:0]  best_score;
    logic [15:0] best_pos;
    logic [15:0] hit_count;
    logic        result_valid;
    logic        busy;

    logic [9:0]  s_best_score;
    logic [3:0]  s_best_pos;
    logic [3:0]  s_hit_count;
    logic        s_result_valid;
    logic        s_busy;

    int total = 0;
    int bad   = 0;
    int acc_q[$];
    int cur_thr;

    always #5 clk = ~clk;

    sw_max_tracker #(.SCORE_WIDTH(10), .POS_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .stall(stall), .start(start),
        .ref_len(ref_len), .threshold(threshold), .V_in(V_in), .init_in(init_in),
        .best_score(best_score), .best_pos(best_pos), .hit_count(hit_count),
        .result_valid(result_valid), .result_ready(result_ready), .busy(busy)
    );

    sw_max_tracker #(.SCORE_WIDTH(10), .POS_WIDTH(4)) dut_small (
        .clk(clk), .rst(rst), .stall(stall), .start(start),
        .ref_len(ref_len[3:0]), .threshold(threshold), .V_in(V_in), .init_in(init_in),
        .best_score(s_best_score), .best_pos(s_best_pos), .hit_count(s_hit_count),
        .result_valid(s_result_valid), .result_ready(result_ready), .busy(s_busy)
    );

    typedef struct {
        int len;
        int thr;
        int v[8];
        int eb;
        int ep;
        int eh;
        int hold;
    } vec_t;

    vec_t tbl[3];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // Reference: max over accepted cells (first index wins), count of cells >= threshold.
    task automatic model(input int width, output int b, output int p, output int h);
        int sat;
        sat = (1 << width) - 1;
        b = 0; p = 0; h = 0;
        foreach (acc_q[i]) begin
            if (acc_q[i] > b) begin
                b = acc_q[i];
                p = i;
            end
            if (acc_q[i] >= cur_thr && h < sat) h++;
        end
    endtask

    task automatic begin_pass(input int len, input int thr, input logic junk_init);
        start     = 1'b1;
        ref_len   = 16'(len);
        threshold = 10'(thr);
        V_in      = 10'd40;
        init_in   = junk_init;
        stall     = 1'b0;
        step();
        start   = 1'b0;
        init_in = 1'b0;
        acc_q.delete();
        cur_thr = thr;
    endtask

    task automatic feed(input int v, input logic init, input logic st);
        V_in    = 10'(v);
        init_in = init;
        stall   = st;
        step();
        if (init && !st) acc_q.push_back(v);
        init_in = 1'b0;
        stall   = 1'b0;
    endtask

    task automatic check_model(input string tag);
        int b, p, h;
        model(16, b, p, h);
        check({tag, " valid"}, 32'(result_valid), 32'd1);
        check({tag, " best"}, 32'($signed(best_score)), 32'(b));
        check({tag, " pos"}, 32'(best_pos), 32'(p));
        check({tag, " hits"}, 32'(hit_count), 32'(h));
    endtask

    task automatic handshake(input string tag);
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        check({tag, " hs valid"}, 32'(result_valid), 32'd0);
        check({tag, " hs busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; start = 1'b0; ref_len = '0; threshold = '0;
        V_in = '0; init_in = 1'b0; result_ready = 1'b0;

        tbl[0] = '{len: 8, thr: 10, v: '{10, 8, 10, 8, 10, 8, 7, 10}, eb: 10, ep: 0, eh: 4, hold: 1};
        tbl[1] = '{len: 8, thr: 10, v: '{8, 8, 8, 8, 8, 8, 20, 18}, eb: 20, ep: 6, eh: 2, hold: 5};
        tbl[2] = '{len: 5, thr: 3, v: '{2, 7, 7, 1, 3, 0, 0, 0}, eb: 7, ep: 1, eh: 3, hold: 0};

        step(); step();
        check("reset valid", 32'(result_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset best", 32'(best_score), 32'd0);
        check("reset pos", 32'(best_pos), 32'd0);
        check("reset hits", 32'(hit_count), 32'd0);
        rst = 1'b0;
        step();

        // Table-driven passes with a hold phase on result_ready=0.
        for (int r = 0; r < 3; r++) begin
            begin_pass(tbl[r].len, tbl[r].thr, 1'b0);
            check($sformatf("row%0d busy", r), 32'(busy), 32'd1);
            for (int i = 0; i < tbl[r].len; i++) begin
                if (i == tbl[r].len - 1)
                    check($sformatf("row%0d pre valid", r), 32'(result_valid), 32'd0);
                feed(tbl[r].v[i], 1'b1, 1'b0);
            end
            for (int k = 0; k <= tbl[r].hold; k++) begin
                check($sformatf("row%0d valid c%0d", r, k), 32'(result_valid), 32'd1);
                check($sformatf("row%0d best c%0d", r, k), 32'($signed(best_score)), 32'(tbl[r].eb));
                check($sformatf("row%0d pos c%0d", r, k), 32'(best_pos), 32'(tbl[r].ep));
                check($sformatf("row%0d hits c%0d", r, k), 32'(hit_count), 32'(tbl[r].eh));
                if (k < tbl[r].hold) step();
            end
            if (r == 1) begin
                result_ready = 1'b1; stall = 1'b1;
                step();
                check("stalled hs valid", 32'(result_valid), 32'd1);
                stall = 1'b0;
            end
            handshake($sformatf("row%0d", r));
            check($sformatf("row%0d idle best", r), 32'($signed(best_score)), 32'(tbl[r].eb));
            step();
        end

        // Gaps and stalls on cells 3 and 6; stalled valid cell must not count.
        begin_pass(8, 10, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == 2 || i == 5) begin
                feed(20, 1'b1, 1'b1);
                feed(500, 1'b0, 1'b0);
            end
            feed(tbl[0].v[i], 1'b1, 1'b0);
        end
        check("gap best", 32'($signed(best_score)), 32'd10);
        check("gap pos", 32'(best_pos), 32'd0);
        check("gap hits", 32'(hit_count), 32'd4);
        check_model("gap");
        handshake("gap");
        step();

        // start while stalled is ignored.
        stall = 1'b1; start = 1'b1; ref_len = 16'd8;
        step();
        stall = 1'b0; start = 1'b0;
        check("stalled start busy", 32'(busy), 32'd0);
        step();

        // Abort after 4 cells; the start-cycle cell is dropped.
        begin_pass(8, 10, 1'b0);
        for (int i = 0; i < 4; i++) feed(30, 1'b1, 1'b0);
        begin_pass(2, 10, 1'b1);
        check("abort busy", 32'(busy), 32'd1);
        check("abort cleared best", 32'(best_score), 32'd0);
        feed(3, 1'b1, 1'b0);
        check("abort no record", 32'(result_valid), 32'd0);
        feed(5, 1'b1, 1'b0);
        check("abort best", 32'($signed(best_score)), 32'd5);
        check("abort pos", 32'(best_pos), 32'd1);
        check("abort hits", 32'(hit_count), 32'd0);
        check("abort valid", 32'(result_valid), 32'd1);
        handshake("abort");
        step();

        // Zero-length pass reports a zero record the next cycle.
        begin_pass(0, 7, 1'b0);
        check("zero valid", 32'(result_valid), 32'd1);
        check("zero best", 32'(best_score), 32'd0);
        check("zero pos", 32'(best_pos), 32'd0);
        check("zero hits", 32'(hit_count), 32'd0);
        check("zero busy", 32'(busy), 32'd0);
        handshake("zero");
        step();

        // Reset in the middle of SCAN.
        begin_pass(8, 10, 1'b0);
        feed(30, 1'b1, 1'b0); feed(12, 1'b1, 1'b0); feed(15, 1'b1, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst best", 32'(best_score), 32'd0);
        check("rst pos", 32'(best_pos), 32'd0);
        check("rst hits", 32'(hit_count), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst valid", 32'(result_valid), 32'd0);
        feed(40, 1'b1, 1'b0);
        check("idle cell dropped", 32'(best_score), 32'd0);

        // Saturation on the 4-bit instance: 15 hits, no wrap.
        begin_pass(15, 0, 1'b0);
        for (int i = 0; i < 15; i++) feed(1, 1'b1, 1'b0);
        check("sat valid", 32'(s_result_valid), 32'd1);
        check("sat hits", 32'(s_hit_count), 32'd15);
        check("sat best", 32'(s_best_score), 32'd1);
        check("sat pos", 32'(s_best_pos), 32'd0);
        check_model("sat16");
        handshake("sat");
        step();

        // Randomized passes with bubbles, stalls and signed values.
        for (int n = 0; n < 20; n++) begin
            int len;
            int cnt;
            len = int'($urandom_range(1, 12));
            begin_pass(len, int'($urandom_range(0, 35)) - 5, 1'($urandom_range(0, 1)));
            cnt = 0;
            while (cnt < len) begin
                int r;
                r = int'($urandom_range(0, 9));
                if (r == 0)
                    feed(int'($urandom_range(0, 500)), 1'($urandom_range(0, 1)), 1'b1);
                else if (r == 1)
                    feed(500, 1'b0, 1'b0);
                else begin
                    feed(int'($urandom_range(0, 45)) - 5, 1'b1, 1'b0);
                    cnt++;
                end
            end
            check_model($sformatf("rand%0d", n));
            handshake($sformatf("rand%0d", n));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
